// File: rtl/matrix_frame_parser.sv
// Receive-side parser for LED-matrix pixel frames arriving on the MAC's
// 8-bit AXI-stream. Pixel packets are written to the framebuffer. All other
// traffic is consumed and discarded; the block never back-pressures.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_HDR   | counting MAC/EtherType bytes 0..13, checking the EtherType
// ST_PARAM | latching start pixel, pixel count and flags (bytes 14..18)
// ST_PIX   | assembling R,G,B triplets and issuing framebuffer writes
// ST_PAD   | all pixels received, discarding padding until tlast
// ST_DROP  | foreign EtherType, discarding until tlast
module matrix_frame_parser #(
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          FB_ADDR_WIDTH = 11,
  parameter int          NUM_PIXELS    = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic                     fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [23:0]              fb_wr_data,
  output logic                     frame_done,
  output logic [15:0]              pkt_ok_count,
  output logic [15:0]              pkt_drop_count
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_PARAM,
    ST_PIX,
    ST_PAD,
    ST_DROP
  } state_t;

  // Pixel address compare is done in 17 bits so S+k never wraps into range.
  localparam logic [16:0] NUM_PIX17 = 17'(NUM_PIXELS);

  state_t                   state_q, state_d;
  logic [4:0]               byte_cnt_q, byte_cnt_d;
  logic [7:0]               etype_hi_q, etype_hi_d;
  logic [15:0]              start_q, start_d;
  logic [15:0]              npix_q, npix_d;
  logic                     swap_q, swap_d;
  logic [1:0]               phase_q, phase_d;
  logic [7:0]               red_q, red_d;
  logic [7:0]               grn_q, grn_d;
  logic [15:0]              pix_k_q, pix_k_d;
  logic                     tready_q;
  logic                     wr_en_q, wr_en_d;
  logic [FB_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]              wr_data_q, wr_data_d;
  logic                     done_q, done_d;
  logic [15:0]              ok_cnt_q, ok_cnt_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;

  logic        beat;
  logic [16:0] pix_addr;
  logic        last_pix;

  assign beat     = s_axis_tvalid & tready_q;
  assign pix_addr = {1'b0, start_q} + {1'b0, pix_k_q};
  assign last_pix = (({1'b0, pix_k_q} + 17'd1) == {1'b0, npix_q});

  // Next-state and output decode; everything holds unless a beat is accepted.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    etype_hi_d = etype_hi_q;
    start_d    = start_q;
    npix_d     = npix_q;
    swap_d     = swap_q;
    phase_d    = phase_q;
    red_d      = red_q;
    grn_d      = grn_q;
    pix_k_d    = pix_k_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    ok_cnt_d   = ok_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (beat) begin
      case (state_q)
        ST_HDR: begin
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (byte_cnt_q == 5'd12) etype_hi_d = s_axis_tdata;
          if (byte_cnt_q == 5'd13) begin
            state_d = ({etype_hi_q, s_axis_tdata} == ETHERTYPE) ? ST_PARAM : ST_DROP;
          end
        end

        ST_PARAM: begin
          byte_cnt_d = byte_cnt_q + 5'd1;
          case (byte_cnt_q)
            5'd14:   start_d[15:8] = s_axis_tdata;
            5'd15:   start_d[7:0]  = s_axis_tdata;
            5'd16:   npix_d[15:8]  = s_axis_tdata;
            5'd17:   npix_d[7:0]   = s_axis_tdata;
            5'd18: begin
              swap_d  = s_axis_tdata[0];
              phase_d = 2'd0;
              pix_k_d = 16'd0;
              state_d = (npix_q != 16'd0) ? ST_PIX : ST_PAD;
            end
            default: ;
          endcase
          if (s_axis_tlast) drop_cnt_d = drop_cnt_q + 16'd1;
        end

        ST_PIX: begin
          case (phase_q)
            2'd0: begin
              red_d   = s_axis_tdata;
              phase_d = 2'd1;
            end
            2'd1: begin
              grn_d   = s_axis_tdata;
              phase_d = 2'd2;
            end
            default: begin
              phase_d   = 2'd0;
              pix_k_d   = pix_k_q + 16'd1;
              wr_en_d   = (pix_addr < NUM_PIX17);
              wr_addr_d = pix_addr[FB_ADDR_WIDTH-1:0];
              wr_data_d = {red_q, grn_q, s_axis_tdata};
              if (last_pix) state_d = ST_PAD;
            end
          endcase
          // Only tlast on the final B byte of a clean frame completes it.
          if (s_axis_tlast) begin
            if ((phase_q == 2'd2) && last_pix && !s_axis_tuser) begin
              ok_cnt_d = ok_cnt_q + 16'd1;
              done_d   = swap_q;
            end else begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
          end
        end

        ST_PAD: begin
          if (s_axis_tlast) begin
            if (s_axis_tuser) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
              ok_cnt_d = ok_cnt_q + 16'd1;
              done_d   = swap_q;
            end
          end
        end

        ST_DROP: ;

        default: state_d = ST_HDR;
      endcase

      if (s_axis_tlast) begin
        state_d    = ST_HDR;
        byte_cnt_d = 5'd0;
      end
    end
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HDR;
      byte_cnt_q <= 5'd0;
      etype_hi_q <= 8'd0;
      start_q    <= 16'd0;
      npix_q     <= 16'd0;
      swap_q     <= 1'b0;
      phase_q    <= 2'd0;
      red_q      <= 8'd0;
      grn_q      <= 8'd0;
      pix_k_q    <= 16'd0;
      tready_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 24'd0;
      done_q     <= 1'b0;
      ok_cnt_q   <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      etype_hi_q <= etype_hi_d;
      start_q    <= start_d;
      npix_q     <= npix_d;
      swap_q     <= swap_d;
      phase_q    <= phase_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      pix_k_q    <= pix_k_d;
      tready_q   <= 1'b1;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      ok_cnt_q   <= ok_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign fb_wr_en       = wr_en_q;
  assign fb_wr_addr     = wr_addr_q;
  assign fb_wr_data     = wr_data_q;
  assign frame_done     = done_q;
  assign pkt_ok_count   = ok_cnt_q;
  assign pkt_drop_count = drop_cnt_q;

endmodule
